decode_stage: RTL and testbench
===============================

# decode_stage

Parametrised decode stage: one buffered instruction slot with valid/ready handshakes on both sides, an internal register file with NWB write-back ports and same-cycle bypass, and a register scoreboard that holds an instruction while a source operand is still pending. It sits between fetch and execute. It replaces the fixed-width, unbuffered decode with a stage that stalls on operand hazards, flushes, and scales in data width, register count and write-back port count.

## Interface
- XLEN, 64, data width of registers, immediates and PCs
- NREG, 32, architectural register count; index width AW = $clog2(NREG)
- NWB, 2, number of write-back ports; a higher index has higher priority
- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-low reset; 0 = in reset
- in_valid  in  1  fetch presents an instruction
- in_ready  out  1  stage accepts this cycle
- in_pc  in  XLEN  instruction PC
- in_instr  in  32  raw instruction
- in_ra1, in_ra2  in  AW  source register indices; index 0 = no source
- in_dst  in  AW  destination index
- in_dst_en  in  1  instruction writes in_dst
- in_imm  in  XLEN  decoded immediate
- out_valid  out  1  instruction issuable to execute
- out_ready  in  1  execute accepts
- out_pc, out_instr, out_imm, out_dst, out_dst_en  out  as above  registered slot payload
- out_srca, out_srcb  out  XLEN  operand values, bypassed
- hazard  out  1  slot valid but blocked by scoreboard
- wb_en  in  NWB  write-back enables
- wb_addr  in  NWB*AW  write-back indices, port k at [k*AW +: AW]
- wb_data  in  NWB*XLEN  write-back data
- flush  in  1  squash slot and clear scoreboard

## Operation
- State: register file rf[NREG], scoreboard busy[NREG], slot (valid bit + payload).
- Reads: operand for index r = 0 if r==0; else wb_data of the highest-index port with wb_en & wb_addr==r this cycle; else rf[r]. Reads are combinational from the slot indices.
- hazard = slot_valid & ((ra1!=0 & busy[ra1] & ~wbhit(ra1)) | (ra2!=0 & busy[ra2] & ~wbhit(ra2))).
- out_valid = slot_valid & ~hazard & ~flush. fire = out_valid & out_ready.
- in_ready = ~flush & (~slot_valid | fire). accept = in_valid & in_ready loads the slot. If there is no accept, a fire clears slot_valid.
- RF write: for each address, the highest-index enabled port wins. Writes to index 0 are dropped.
- Scoreboard: a wb hit clears busy[r]. A fire with out_dst_en & out_dst!=0 sets busy[out_dst]. If a set and a clear hit the same index in one cycle, the set wins.
- flush: slot_valid←0 and all busy←0. RF writes in the same cycle still complete. No accept, no fire.
- Busy is never set for index 0. An instruction reading its own pending dst waits for write-back.

## Timing
- Reset (reset==0, asynchronous) values:
  - rf all 0, busy all 0, slot_valid 0, payload 0.
  - out_valid 0, hazard 0, out_srca/out_srcb 0, in_ready 1.
- Latency: an instruction accepted at edge N is presented from cycle N+1. With a full slot, back-to-back issue runs at 1/cycle.
- Bypass has zero cycle latency. A wb in cycle C both unblocks and supplies the operand in cycle C.
- Payload is held stable while out_valid & ~out_ready, and across hazard cycles.
- Reset asserted mid-operation drops the slot and scoreboard immediately. The first accept is possible on the first edge after reset rises.

## Test plan
- Reset then stream: 3 instructions with no dst, out_ready=1 → out_valid on cycles 1,2,3 after the accepts; in_ready stays 1; payload matches input.
- RAW hazard:
  - Issue A (dst=5), then B (ra1=5).
  - Expected: hazard=1 and out_valid=0 until wb_en[0], addr=5, data=0xDEAD; that cycle out_valid=1 and out_srca=0xDEAD; the next cycle rf[5]=0xDEAD.
- Port priority: wb0 and wb1 both write x7 (0x11 / 0x22) while the slot reads ra2=7 → out_srcb=0x22, rf[7]=0x22. A write to x0 → reads stay 0.
- Backpressure: out_ready=0 for 4 cycles with the slot full → in_ready=0 and the payload is stable. Release → fire and a new accept on the same edge.
- Flush: busy[3]=1 and a blocked slot, assert flush → next cycle slot_valid=0, busy all 0, in_ready=1. A concurrent wb to x9 lands.
- Set/clear race: a fire with dst=4 and a wb to x4 on the same edge → busy[4]=1 afterwards.

Source files
------------

// File: rtl/decode_stage.sv
// Decode stage: one buffered instruction slot, register file with NWB bypassed write-back ports, and a busy scoreboard.
// Latency: an instruction accepted at edge N is presented from cycle N+1; operand bypass adds no cycles.
// Backpressure: in_ready drops while the slot holds an instruction that cannot fire (hazard, out_ready low) or on flush.
module decode_stage #(
    parameter int XLEN = 64,
    parameter int NREG = 32,
    parameter int NWB  = 2,
    localparam int AW  = $clog2(NREG)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [XLEN-1:0]       in_pc,
    input  logic [31:0]           in_instr,
    input  logic [AW-1:0]         in_ra1,
    input  logic [AW-1:0]         in_ra2,
    input  logic [AW-1:0]         in_dst,
    input  logic                  in_dst_en,
    input  logic [XLEN-1:0]       in_imm,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [XLEN-1:0]       out_pc,
    output logic [31:0]           out_instr,
    output logic [XLEN-1:0]       out_imm,
    output logic [AW-1:0]         out_dst,
    output logic                  out_dst_en,
    output logic [XLEN-1:0]       out_srca,
    output logic [XLEN-1:0]       out_srcb,
    output logic                  hazard,
    input  logic [NWB-1:0]        wb_en,
    input  logic [NWB*AW-1:0]     wb_addr,
    input  logic [NWB*XLEN-1:0]   wb_data,
    input  logic                  flush
);

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [31:0]     instr;
        logic [XLEN-1:0] imm;
        logic [AW-1:0]   dst;
        logic            dst_en;
        logic [AW-1:0]   ra1;
        logic [AW-1:0]   ra2;
    } slot_t;

    logic [XLEN-1:0] rf [NREG];
    logic [NREG-1:0] busy;
    logic [NREG-1:0] busy_nxt;
    logic            slot_vld;
    slot_t           slot_q;
    slot_t           slot_d;

    logic [NREG-1:0] wb_hit;
    logic [XLEN-1:0] wb_val [NREG];
    logic            pend_a;
    logic            pend_b;
    logic            fire;
    logic            accept;

    // Later ports overwrite earlier ones, so the highest-index enabled port wins per address.
    always_comb begin
        wb_hit = '0;
        for (int r = 0; r < NREG; r++) wb_val[r] = '0;
        for (int k = 0; k < NWB; k++) begin
            if (wb_en[k]) begin
                wb_hit[wb_addr[k*AW +: AW]] = 1'b1;
                wb_val[wb_addr[k*AW +: AW]] = wb_data[k*XLEN +: XLEN];
            end
        end
    end

    assign out_srca = (slot_q.ra1 == '0) ? '0 :
                      wb_hit[slot_q.ra1] ? wb_val[slot_q.ra1] : rf[slot_q.ra1];
    assign out_srcb = (slot_q.ra2 == '0) ? '0 :
                      wb_hit[slot_q.ra2] ? wb_val[slot_q.ra2] : rf[slot_q.ra2];

    assign pend_a    = (slot_q.ra1 != '0) && busy[slot_q.ra1] && !wb_hit[slot_q.ra1];
    assign pend_b    = (slot_q.ra2 != '0) && busy[slot_q.ra2] && !wb_hit[slot_q.ra2];
    assign hazard    = slot_vld && (pend_a || pend_b);
    assign out_valid = slot_vld && !hazard && !flush;
    assign fire      = out_valid && out_ready;
    assign in_ready  = !flush && (!slot_vld || fire);
    assign accept    = in_valid && in_ready;

    assign slot_d = {in_pc, in_instr, in_imm, in_dst, in_dst_en, in_ra1, in_ra2};

    assign out_pc     = slot_q.pc;
    assign out_instr  = slot_q.instr;
    assign out_imm    = slot_q.imm;
    assign out_dst    = slot_q.dst;
    assign out_dst_en = slot_q.dst_en;

    // An issuing producer marks its dst busy after the clear, so a same-edge write-back cannot unmark it.
    always_comb begin
        busy_nxt = busy & ~wb_hit;
        if (fire && slot_q.dst_en && (slot_q.dst != '0))
            busy_nxt[slot_q.dst] = 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int r = 0; r < NREG; r++) rf[r] <= '0;
        end else begin
            for (int r = 1; r < NREG; r++)
                if (wb_hit[r]) rf[r] <= wb_val[r];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            busy <= '0;
        else if (flush)
            busy <= '0;
        else
            busy <= busy_nxt;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            slot_vld <= 1'b0;
            slot_q   <= '0;
        end else if (flush) begin
            slot_vld <= 1'b0;
        end else if (accept) begin
            slot_vld <= 1'b1;
            slot_q   <= slot_d;
        end else if (fire) begin
            slot_vld <= 1'b0;
        end
    end

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: directed scenarios with literal expectations, then random traffic against an array-based model.
module tb_decode_stage;
    localparam int XLEN = 64;
    localparam int NREG = 32;
    localparam int NWB  = 2;
    localparam int AW   = 5;

    logic                clk = 1'b0;
    logic                reset;
    logic                in_valid;
    logic                in_ready;
    logic [XLEN-1:0]     in_pc;
    logic [31:0]         in_instr;
    logic [AW-1:0]       in_ra1, in_ra2, in_dst;
    logic                in_dst_en;
    logic [XLEN-1:0]     in_imm;
    logic                out_valid;
    logic                out_ready;
    logic [XLEN-1:0]     out_pc, out_imm, out_srca, out_srcb;
    logic [31:0]         out_instr;
    logic [AW-1:0]       out_dst;
    logic                out_dst_en;
    logic                hazard;
    logic [NWB-1:0]      wb_en;
    logic [NWB*AW-1:0]   wb_addr;
    logic [NWB*XLEN-1:0] wb_data;
    logic                flush;

    decode_stage #(.XLEN(XLEN), .NREG(NREG), .NWB(NWB)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_instr(in_instr),
        .in_ra1(in_ra1), .in_ra2(in_ra2), .in_dst(in_dst), .in_dst_en(in_dst_en), .in_imm(in_imm),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_instr(out_instr),
        .out_imm(out_imm), .out_dst(out_dst), .out_dst_en(out_dst_en),
        .out_srca(out_srca), .out_srcb(out_srcb), .hazard(hazard),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data), .flush(flush)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: architectural registers, pending set, and the held instruction.
    logic [63:0]   m_rf [NREG];
    bit            m_busy [NREG];
    bit            m_vld;
    logic [63:0]   m_pc, m_imm;
    logic [31:0]   m_instr;
    logic [AW-1:0] m_dst, m_ra1, m_ra2;
    bit            m_dst_en;

    function automatic bit m_hit(input logic [AW-1:0] r);
        for (int k = 0; k < NWB; k++)
            if (wb_en[k] && wb_addr[k*AW +: AW] == r) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [63:0] m_read(input logic [AW-1:0] r);
        if (r == 0) return 64'd0;
        for (int k = NWB-1; k >= 0; k--)
            if (wb_en[k] && wb_addr[k*AW +: AW] == r) return wb_data[k*XLEN +: XLEN];
        return m_rf[r];
    endfunction

    function automatic bit m_waiting(input logic [AW-1:0] r);
        return (r != 0) && m_busy[r] && !m_hit(r);
    endfunction

    always @(negedge clk) begin
        bit hz, ov, ir, fire, acc;
        if (!reset) begin
            for (int r = 0; r < NREG; r++) begin m_rf[r] = 64'd0; m_busy[r] = 1'b0; end
            m_vld = 0; m_pc = 0; m_imm = 0; m_instr = 0; m_dst = 0; m_ra1 = 0; m_ra2 = 0; m_dst_en = 0;
        end
        hz   = m_vld && (m_waiting(m_ra1) || m_waiting(m_ra2));
        ov   = m_vld && !hz && !flush;
        ir   = !flush && (!m_vld || (ov && out_ready));
        fire = ov && out_ready;
        acc  = in_valid && ir;
        chk("out_valid", out_valid, ov);
        chk("in_ready", in_ready, ir);
        chk("hazard", hazard, hz);
        chk("out_pc", out_pc, m_pc);
        chk("out_instr", out_instr, m_instr);
        chk("out_imm", out_imm, m_imm);
        chk("out_dst", out_dst, m_dst);
        chk("out_dst_en", out_dst_en, m_dst_en);
        chk("out_srca", out_srca, m_read(m_ra1));
        chk("out_srcb", out_srcb, m_read(m_ra2));
        if (reset) begin
            if (flush) begin
                for (int r = 0; r < NREG; r++) m_busy[r] = 1'b0;
            end else begin
                for (int r = 0; r < NREG; r++) if (m_hit(r[AW-1:0])) m_busy[r] = 1'b0;
                if (fire && m_dst_en && m_dst != 0) m_busy[m_dst] = 1'b1;
            end
            for (int r = 1; r < NREG; r++)
                if (m_hit(r[AW-1:0])) m_rf[r] = m_read(r[AW-1:0]);
            if (flush) m_vld = 0;
            else if (acc) begin
                m_vld = 1; m_pc = in_pc; m_instr = in_instr; m_imm = in_imm;
                m_dst = in_dst; m_dst_en = in_dst_en; m_ra1 = in_ra1; m_ra2 = in_ra2;
            end else if (fire) m_vld = 0;
        end
    end

    task automatic nxt();
        @(posedge clk); #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic idle();
        in_valid = 0; wb_en = '0; flush = 0; out_ready = 1;
    endtask

    task automatic ins(input logic [63:0] pc, input logic [AW-1:0] ra1, input logic [AW-1:0] ra2,
                       input logic [AW-1:0] dst, input bit dst_en);
        in_valid = 1; in_pc = pc; in_instr = pc[31:0] ^ 32'h13; in_imm = pc << 1;
        in_ra1 = ra1; in_ra2 = ra2; in_dst = dst; in_dst_en = dst_en;
    endtask

    task automatic wb(input int k, input logic [AW-1:0] a, input logic [63:0] d);
        wb_en[k] = 1'b1;
        wb_addr[k*AW +: AW] = a;
        wb_data[k*XLEN +: XLEN] = d;
    endtask

    initial begin
        reset = 0; in_pc = 0; in_instr = 0; in_ra1 = 0; in_ra2 = 0; in_dst = 0; in_dst_en = 0; in_imm = 0;
        wb_addr = '0; wb_data = '0;
        idle();
        mid();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_hazard", hazard, 0);
        chk("rst_srca", out_srca, 0);
        chk("rst_srcb", out_srcb, 0);
        chk("rst_in_ready", in_ready, 1);
        nxt();

        // Stream of three independent instructions.
        reset = 1;
        ins(64'h100, 0, 0, 0, 0); mid(); chk("s_in_ready", in_ready, 1); nxt();
        ins(64'h104, 0, 0, 0, 0); mid();
        chk("s_vld1", out_valid, 1); chk("s_pc1", out_pc, 64'h100); chk("s_rdy1", in_ready, 1); nxt();
        ins(64'h108, 0, 0, 0, 0); mid();
        chk("s_pc2", out_pc, 64'h104); chk("s_instr2", out_instr, 32'h117); nxt();
        idle(); mid();
        chk("s_vld3", out_valid, 1); chk("s_pc3", out_pc, 64'h108); chk("s_imm3", out_imm, 64'h210); nxt();
        mid(); chk("s_empty", out_valid, 0); nxt();

        // RAW hazard resolved by a bypassed write-back.
        ins(64'h200, 0, 0, 5, 1); mid(); nxt();
        ins(64'h204, 5, 0, 0, 0); mid(); chk("raw_a_vld", out_valid, 1); chk("raw_a_dst", out_dst, 5); nxt();
        idle(); mid();
        chk("raw_hz1", hazard, 1); chk("raw_vld1", out_valid, 0); chk("raw_rdy1", in_ready, 0); nxt();
        mid(); chk("raw_hz2", hazard, 1); nxt();
        wb(0, 5, 64'hDEAD); ins(64'h208, 5, 5, 0, 0); mid();
        chk("raw_hz_wb", hazard, 0); chk("raw_vld_wb", out_valid, 1);
        chk("raw_srca_wb", out_srca, 64'hDEAD); chk("raw_rdy_wb", in_ready, 1); nxt();
        idle(); mid();
        chk("raw_c_pc", out_pc, 64'h208); chk("raw_c_hz", hazard, 0);
        chk("raw_rf5_a", out_srca, 64'hDEAD); chk("raw_rf5_b", out_srcb, 64'hDEAD);
        chk("model_rf5", m_rf[5], 64'hDEAD); nxt();

        // Write-back port priority and x0 writes.
        ins(64'h300, 0, 7, 0, 0); mid(); nxt();
        wb(0, 7, 64'h11); wb(1, 7, 64'h22); ins(64'h304, 7, 0, 0, 0); mid();
        chk("prio_srcb", out_srcb, 64'h22); nxt();
        idle(); wb(1, 0, 64'h55); mid();
        chk("prio_rf7", out_srca, 64'h22); chk("x0_srcb", out_srcb, 0); nxt();

        // Backpressure holds the payload and blocks input.
        idle(); ins(64'h400, 0, 0, 0, 0); out_ready = 0; mid(); nxt();
        for (int i = 0; i < 4; i++) begin
            ins(64'h500, 0, 0, 0, 0); out_ready = 0; mid();
            chk("bp_rdy", in_ready, 0); chk("bp_vld", out_valid, 1); chk("bp_pc", out_pc, 64'h400); nxt();
        end
        out_ready = 1; mid(); chk("bp_rel_rdy", in_ready, 1); chk("bp_rel_pc", out_pc, 64'h400); nxt();
        idle(); mid(); chk("bp_new_pc", out_pc, 64'h500); chk("bp_new_vld", out_valid, 1); nxt();

        // Flush clears a blocked slot and the scoreboard; concurrent write-back lands.
        ins(64'h600, 0, 0, 3, 1); mid(); nxt();
        ins(64'h604, 3, 0, 0, 0); mid(); nxt();
        idle(); mid(); chk("fl_hz", hazard, 1); nxt();
        flush = 1; wb(0, 9, 64'h99); mid(); chk("fl_vld", out_valid, 0); chk("fl_rdy", in_ready, 0); nxt();
        idle(); ins(64'h608, 3, 9, 0, 0); mid();
        chk("fl_after_vld", out_valid, 0); chk("fl_after_hz", hazard, 0); chk("fl_after_rdy", in_ready, 1); nxt();
        idle(); mid();
        chk("fl_busy_clr", hazard, 0); chk("fl_k_vld", out_valid, 1);
        chk("fl_srca", out_srca, 0); chk("fl_wb9", out_srcb, 64'h99); nxt();

        // Issue setting busy races a write-back clearing it: the set must stick.
        ins(64'h700, 0, 0, 4, 1); mid(); nxt();
        wb(0, 4, 64'h44); ins(64'h704, 4, 0, 0, 0); mid();
        chk("race_vld", out_valid, 1); chk("race_dst", out_dst, 4); nxt();
        idle(); mid(); chk("race_hz", hazard, 1); chk("race_blk", out_valid, 0); chk("model_busy4", m_busy[4], 1); nxt();
        wb(1, 4, 64'h45); mid(); chk("race_srca", out_srca, 64'h45); chk("race_go", out_valid, 1); nxt();

        // Reset in the middle of a stall.
        idle(); ins(64'h800, 0, 0, 6, 1); mid(); nxt();
        ins(64'h804, 6, 0, 0, 0); mid(); nxt();
        idle(); mid(); chk("mr_hz", hazard, 1); nxt();
        reset = 0; mid();
        chk("mr_vld", out_valid, 0); chk("mr_hz0", hazard, 0); chk("mr_rdy", in_ready, 1); chk("mr_pc", out_pc, 0); nxt();
        reset = 1; ins(64'h808, 6, 0, 0, 0); mid(); chk("mr_acc_rdy", in_ready, 1); nxt();
        idle(); mid();
        chk("mr_hz_after", hazard, 0); chk("mr_vld_after", out_valid, 1);
        chk("mr_pc_after", out_pc, 64'h808); chk("mr_srca", out_srca, 0); nxt();

        // Random traffic over a small register window so hazards and bypasses are frequent.
        for (int c = 0; c < 3000; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_pc     = {$urandom, $urandom};
            in_instr  = $urandom;
            in_imm    = {$urandom, $urandom};
            in_ra1    = AW'($urandom_range(0, 7));
            in_ra2    = AW'($urandom_range(0, 7));
            in_dst    = AW'($urandom_range(0, 7));
            in_dst_en = $urandom_range(0, 1);
            out_ready = ($urandom_range(0, 3) != 0);
            for (int k = 0; k < NWB; k++) begin
                wb_en[k] = ($urandom_range(0, 9) < 3);
                wb_addr[k*AW +: AW] = AW'($urandom_range(0, 7));
                wb_data[k*XLEN +: XLEN] = {$urandom, $urandom};
            end
            flush = ($urandom_range(0, 39) == 0);
            reset = ($urandom_range(0, 199) != 0);
            if (!reset) flush = 0;
            nxt();
        end
        reset = 1;
        idle();
        mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
